// File: rtl/arb_req_queue_if.sv
// Handshake bundle between the two clients, the arbiter, the downstream sink and arb_req_queue.
// The master side drives pushes, grants and out_ready; the slave side is the queue.
interface arb_req_queue_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in0_valid;
  logic [DATA_W-1:0] in0_data;
  logic              in0_ready;
  logic              in1_valid;
  logic [DATA_W-1:0] in1_data;
  logic              in1_ready;
  logic [1:0]        request;
  logic [1:0]        grant;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_src;
  logic              out_ready;
  logic [CNT_W-1:0]  count0;
  logic [CNT_W-1:0]  count1;
  logic              grant_err;

  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, grant, out_ready,
    input  in0_ready, in1_ready, request, out_valid, out_data, out_src,
           count0, count1, grant_err
  );

  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, grant, out_ready,
    output in0_ready, in1_ready, request, out_valid, out_data, out_src,
           count0, count1, grant_err
  );
endinterface

// File: rtl/arb_req_queue.sv
// Two per-client FIFOs feeding a 2-client arbiter; the granted head word is popped
// into a single registered output stage with valid/ready backpressure.
module arb_req_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic               clk,
  input  logic               reset,
  arb_req_queue_if.slave     bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

  logic [DATA_W-1:0] mem0_r [DEPTH];
  logic [DATA_W-1:0] mem1_r [DEPTH];
  logic [PTR_W-1:0]  wr0_r, rd0_r, wr1_r, rd1_r;
  logic [CNT_W-1:0]  count0_r, count1_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_src_r;
  logic              grant_err_r;

  logic ne0_s, ne1_s, ready0_s, ready1_s;
  logic push0_s, push1_s, pop0_s, pop1_s;
  logic out_free_s, bad_grant_s;

  assign ne0_s      = (count0_r != ZERO_CNT);
  assign ne1_s      = (count1_r != ZERO_CNT);
  assign ready0_s   = (count0_r != FULL_CNT);
  assign ready1_s   = (count1_r != FULL_CNT);
  assign out_free_s = !out_valid_r || bus.out_ready;

  // Handshake decode; grant legality is judged independently of output stall.
  always_comb begin
    push0_s     = bus.in0_valid && ready0_s;
    push1_s     = bus.in1_valid && ready1_s;
    pop0_s      = 1'b0;
    pop1_s      = 1'b0;
    bad_grant_s = 1'b0;
    case (bus.grant)
      2'b01: begin
        pop0_s      = ne0_s && out_free_s;
        bad_grant_s = !ne0_s;
      end
      2'b10: begin
        pop1_s      = ne1_s && out_free_s;
        bad_grant_s = !ne1_s;
      end
      2'b11: bad_grant_s = 1'b1;
      default: bad_grant_s = 1'b0;
    endcase
  end

  // Storage arrays carry no reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push0_s) mem0_r[wr0_r] <= bus.in0_data;
    if (push1_s) mem1_r[wr1_r] <= bus.in1_data;
  end

  // Pointer and occupancy bookkeeping for both FIFOs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr0_r    <= {PTR_W{1'b0}};
      rd0_r    <= {PTR_W{1'b0}};
      wr1_r    <= {PTR_W{1'b0}};
      rd1_r    <= {PTR_W{1'b0}};
      count0_r <= ZERO_CNT;
      count1_r <= ZERO_CNT;
    end else begin
      if (push0_s) wr0_r <= wr0_r + ONE_PTR;
      if (pop0_s)  rd0_r <= rd0_r + ONE_PTR;
      if (push1_s) wr1_r <= wr1_r + ONE_PTR;
      if (pop1_s)  rd1_r <= rd1_r + ONE_PTR;
      case ({push0_s, pop0_s})
        2'b10:   count0_r <= count0_r + ONE_CNT;
        2'b01:   count0_r <= count0_r - ONE_CNT;
        default: count0_r <= count0_r;
      endcase
      case ({push1_s, pop1_s})
        2'b10:   count1_r <= count1_r + ONE_CNT;
        2'b01:   count1_r <= count1_r - ONE_CNT;
        default: count1_r <= count1_r;
      endcase
    end
  end

  // Output stage; data and source hold whenever no new word is loaded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      out_src_r   <= 1'b0;
      grant_err_r <= 1'b0;
    end else begin
      if (pop0_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= mem0_r[rd0_r];
        out_src_r   <= 1'b0;
      end else if (pop1_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= mem1_r[rd1_r];
        out_src_r   <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      grant_err_r <= grant_err_r || bad_grant_s;
    end
  end

  assign bus.in0_ready = ready0_s;
  assign bus.in1_ready = ready1_s;
  assign bus.request   = {ne1_s, ne0_s};
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_src   = out_src_r;
  assign bus.count0    = count0_r;
  assign bus.count1    = count1_r;
  assign bus.grant_err = grant_err_r;
endmodule

// File: tb/tb_arb_req_queue.sv
// Directed bench for arb_req_queue: inputs change 1 time unit after posedge,
// outputs are checked in the same window against hand-computed values.
module tb_arb_req_queue;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  arb_req_queue_if #(.DATA_W(8), .DEPTH(4)) bus ();

  arb_req_queue #(.DATA_W(8), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic s);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_data"},  {24'd0, bus.out_data},  {24'd0, d});
    chk({tag, "_src"},   {31'd0, bus.out_src},   {31'd0, s});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus.in0_valid = 1'b0;
    bus.in0_data  = 8'h00;
    bus.in1_valid = 1'b0;
    bus.in1_data  = 8'h00;
    bus.grant     = 2'b00;
    bus.out_ready = 1'b1;

    // Reset values, before any clock edge.
    #4;
    chk("rst_request",  {30'd0, bus.request},   32'd0);
    chk("rst_valid",    {31'd0, bus.out_valid}, 32'd0);
    chk("rst_data",     {24'd0, bus.out_data},  32'd0);
    chk("rst_src",      {31'd0, bus.out_src},   32'd0);
    chk("rst_rdy0",     {31'd0, bus.in0_ready}, 32'd1);
    chk("rst_rdy1",     {31'd0, bus.in1_ready}, 32'd1);
    chk("rst_cnt0",     {29'd0, bus.count0},    32'd0);
    chk("rst_cnt1",     {29'd0, bus.count1},    32'd0);
    chk("rst_err",      {31'd0, bus.grant_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Simultaneous pushes, then one pop from each client.
    bus.in0_valid = 1'b1; bus.in0_data = 8'hA1;
    bus.in1_valid = 1'b1; bus.in1_data = 8'hB2;
    tick();
    bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
    chk("t2_request", {30'd0, bus.request}, 32'd3);
    chk("t2_cnt0",    {29'd0, bus.count0},  32'd1);
    chk("t2_cnt1",    {29'd0, bus.count1},  32'd1);
    bus.grant = 2'b01;
    tick();
    bus.grant = 2'b00;
    chk_out("t2_pop0", 8'hA1, 1'b0);
    chk("t2_req_after", {30'd0, bus.request}, 32'd2);
    chk("t2_cnt0_after", {29'd0, bus.count0}, 32'd0);
    bus.grant = 2'b10;
    tick();
    bus.grant = 2'b00;
    chk_out("t2_pop1", 8'hB2, 1'b1);
    tick();
    chk("t2_drain_valid", {31'd0, bus.out_valid}, 32'd0);

    // Fill client 0 past full; the fifth word must be dropped.
    for (int i = 0; i < 5; i++) begin
      bus.in0_valid = 1'b1;
      bus.in0_data  = 8'h10 + 8'(i);
      tick();
      if (i == 3) begin
        chk("t3_rdy0_full", {31'd0, bus.in0_ready}, 32'd0);
        chk("t3_cnt0_full", {29'd0, bus.count0},    32'd4);
      end
    end
    bus.in0_valid = 1'b0;
    chk("t3_cnt0_drop", {29'd0, bus.count0}, 32'd4);
    bus.grant = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) bus.grant = 2'b00;
      chk_out("t3_drain", 8'h10 + 8'(i), 1'b0);
      chk("t3_cnt0", {29'd0, bus.count0}, 32'(3 - i));
    end
    chk("t3_req0", {31'd0, bus.request[0]}, 32'd0);
    tick();
    chk("t3_idle_valid", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure on client 1 with grant held.
    for (int i = 0; i < 3; i++) begin
      bus.in1_valid = 1'b1;
      bus.in1_data  = 8'h20 + 8'(i);
      tick();
    end
    bus.in1_valid = 1'b0;
    chk("t4_cnt1", {29'd0, bus.count1}, 32'd3);
    bus.out_ready = 1'b0;
    bus.grant     = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("t4_stall", 8'h20, 1'b1);
      chk("t4_stall_cnt1", {29'd0, bus.count1}, 32'd2);
    end
    bus.out_ready = 1'b1;
    tick();
    chk_out("t4_resume", 8'h21, 1'b1);
    chk("t4_resume_cnt1", {29'd0, bus.count1}, 32'd1);
    // Simultaneous push and pop on client 1 keeps the count.
    bus.in1_valid = 1'b1; bus.in1_data = 8'h30;
    tick();
    bus.in1_valid = 1'b0;
    chk_out("t4_pushpop", 8'h22, 1'b1);
    chk("t4_pushpop_cnt1", {29'd0, bus.count1}, 32'd1);
    tick();
    bus.grant = 2'b00;
    chk_out("t4_last", 8'h30, 1'b1);
    chk("t4_cnt1_empty", {29'd0, bus.count1}, 32'd0);
    chk("t4_no_err", {31'd0, bus.grant_err}, 32'd0);
    tick();

    // Grant to an empty queue.
    bus.grant = 2'b01;
    tick();
    bus.grant = 2'b00;
    chk("t5_empty_err",   {31'd0, bus.grant_err}, 32'd1);
    chk("t5_empty_valid", {31'd0, bus.out_valid}, 32'd0);
    tick(); tick();
    chk("t5_sticky", {31'd0, bus.grant_err}, 32'd1);
    reset = 1'b0;
    #2;
    chk("t5_rst_err", {31'd0, bus.grant_err}, 32'd0);
    reset = 1'b1;
    tick();

    // Multi-hot grant with both queues non-empty.
    bus.in0_valid = 1'b1; bus.in0_data = 8'h55;
    bus.in1_valid = 1'b1; bus.in1_data = 8'h66;
    tick();
    bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
    chk("t5_err_clean", {31'd0, bus.grant_err}, 32'd0);
    bus.grant = 2'b11;
    tick();
    bus.grant = 2'b00;
    chk("t5_mh_err",   {31'd0, bus.grant_err}, 32'd1);
    chk("t5_mh_cnt0",  {29'd0, bus.count0},    32'd1);
    chk("t5_mh_cnt1",  {29'd0, bus.count1},    32'd1);
    chk("t5_mh_valid", {31'd0, bus.out_valid}, 32'd0);

    // Fill client 0, then push into full FIFO while popping: push is ignored.
    for (int i = 0; i < 3; i++) begin
      bus.in0_valid = 1'b1;
      bus.in0_data  = 8'h41 + 8'(i);
      tick();
    end
    chk("t6_cnt0_full", {29'd0, bus.count0}, 32'd4);
    bus.in0_data = 8'h44;
    bus.grant    = 2'b01;
    tick();
    bus.in0_valid = 1'b0;
    bus.grant     = 2'b00;
    chk_out("t6_pop", 8'h55, 1'b0);
    chk("t6_cnt0_ign", {29'd0, bus.count0}, 32'd3);

    // Asynchronous reset mid-stream, away from any clock edge.
    reset = 1'b0;
    #1;
    chk("t7_cnt0",    {29'd0, bus.count0},    32'd0);
    chk("t7_cnt1",    {29'd0, bus.count1},    32'd0);
    chk("t7_valid",   {31'd0, bus.out_valid}, 32'd0);
    chk("t7_request", {30'd0, bus.request},   32'd0);
    chk("t7_err",     {31'd0, bus.grant_err}, 32'd0);
    reset = 1'b1;
    tick();
    bus.in0_valid = 1'b1; bus.in0_data = 8'h77;
    tick();
    bus.in0_valid = 1'b0;
    chk("t7_push_cnt0", {29'd0, bus.count0},  32'd1);
    chk("t7_push_req",  {30'd0, bus.request}, 32'd1);
    bus.grant = 2'b01;
    tick();
    bus.grant = 2'b00;
    chk_out("t7_pop", 8'h77, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
